// File: rtl/ofifo.sv
// Output-side column buffer for the systolic array: per-column lanes absorb skewed
// partial-sum writes and release one aligned row per pop.
module ofifo #(
  parameter int col   = 8,
  parameter int bw    = 16,
  parameter int depth = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [col*bw-1:0] in,
  input  logic [col-1:0]    wr,
  input  logic              rd,
  output logic [col*bw-1:0] out,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_valid
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(depth);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [bw-1:0]     mem_q [col][depth];
  logic [AW-1:0]     wp_q [col];
  logic [AW-1:0]     wp_d [col];
  logic [CW-1:0]     cnt_q [col];
  logic [CW-1:0]     cnt_d [col];
  // All lanes pop together, so one read pointer serves every lane.
  logic [AW-1:0]     rp_q, rp_d;
  logic [col*bw-1:0] out_q, out_d;
  logic [col-1:0]    lane_full_s, lane_nonempty_s, wr_ok_s;
  logic              pop_s;

  // Per-lane status decoded from registered counts only.
  always_comb begin
    lane_full_s     = '0;
    lane_nonempty_s = '0;
    for (int i = 0; i < col; i++) begin
      lane_full_s[i]     = (cnt_q[i] == CNT_FULL);
      lane_nonempty_s[i] = (cnt_q[i] != '0);
    end
  end

  assign o_full  = |lane_full_s;
  assign o_ready = ~o_full;
  assign o_valid = &lane_nonempty_s;
  assign out     = out_q;

  // Next-state for pointers, counts and the output row.
  always_comb begin
    pop_s   = rd & o_valid;
    wr_ok_s = wr & ~lane_full_s;
    rp_d    = pop_s ? (rp_q + PTR_ONE) : rp_q;
    out_d   = out_q;
    for (int i = 0; i < col; i++) begin
      wp_d[i] = wr_ok_s[i] ? (wp_q[i] + PTR_ONE) : wp_q[i];
      case ({wr_ok_s[i], pop_s})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    if (pop_s) begin
      for (int i = 0; i < col; i++) begin
        out_d[i*bw +: bw] = mem_q[i][rp_q];
      end
    end else begin
      out_d = out_q;
    end
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rp_q  <= '0;
      out_q <= '0;
      for (int i = 0; i < col; i++) begin
        wp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      rp_q  <= rp_d;
      out_q <= out_d;
      for (int i = 0; i < col; i++) begin
        wp_q[i]  <= wp_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Lane storage; contents are meaningless after reset, so it carries no clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (wr_ok_s[i]) begin
        mem_q[i][wp_q[i]] <= in[i*bw +: bw];
      end
    end
  end

endmodule

// File: doc/ofifo.md
# ofifo

Output-side column buffer for the systolic array: the receiving end of the path that the L0 input buffer feeds. Each of `col` array columns pushes partial sums independently, under its own write strobe, in the skewed order the array produces them. The block re-aligns these into full rows and hands one complete row (all columns) per read to the downstream SRAM or accumulator writer. It also reports backpressure (`o_full`) to the array controller and row availability (`o_valid`) to the reader.

## Interface
- `col`, 8, number of array columns (independent lanes)
- `bw`, 16, bits per column word (psum width)
- `depth`, 64, words per column lane; power of two, ≥ 2
- `clk` input 1: single clock; all state updates on rising edge
- `reset` input 1: asynchronous, active-high reset; clears all state immediately
- `in` input col*bw: column data; lane i = `in[bw*(i+1)-1 : bw*i]`
- `wr` input col: per-column write strobe; bit i pushes lane i
- `rd` input 1: pop one full row (one word from every lane)
- `out` output col*bw: last popped row, lane packing as `in`
- `o_full` output 1: at least one lane holds `depth` words
- `o_ready` output 1: `~o_full`, so every lane can accept a write
- `o_valid` output 1: every lane holds ≥ 1 word, so a row is available

## Operation
- Per lane i, keep:
  - storage `mem_i[depth]`
  - write pointer `wp_i` and read pointer `rp_i`, each log2(depth) bits, wrapping modulo `depth`
  - occupancy `cnt_i`, log2(depth)+1 bits, range 0..depth
- Write, lane i: if `wr[i]` and `cnt_i < depth` (value before the edge):
  - `mem_i[wp_i] <= lane i of in`, `wp_i++`
  - A write to a full lane is dropped: no state change, even if a row pop happens in the same cycle.
- Row pop: accepted iff `rd` and `o_valid` (value before the edge). On acceptance, for every lane:
  - `out` lane i <= `mem_i[rp_i]`
  - `rp_i++`
  - `rd` while `!o_valid` is ignored: pointers, counts and `out` are unchanged.
- Count update per lane: +1 for an accepted write, −1 for an accepted pop, unchanged when both occur.
- Simultaneous accepted write and pop on a lane with `cnt_i == 1`: the pop returns the old head, and the new word becomes the head.
- Flags are combinational from registered counts only. They never depend on same-cycle `wr`/`rd`.
  - `o_full = OR(cnt_i == depth)`
  - `o_ready = ~o_full`
  - `o_valid = AND(cnt_i != 0)`
- Lanes are fully independent except that `rd` pops all lanes together. Skew between lanes is absorbed up to `depth` words.
- No state machine. Behaviour is defined entirely by the per-lane pointer/count datapath.

## Timing
- Reset (asserted, asynchronous): all pointers = 0, all counts = 0, `out` = 0, `o_full` = 0, `o_ready` = 1, `o_valid` = 0.
  - Memory contents are don't-care.
  - Reset mid-stream discards all buffered words.
  - The first edge after reset deasserts is a normal operating edge.
- Write-to-flag latency: a write at edge N that completes a row raises `o_valid` after edge N (visible in cycle N+1). A pop may be issued in that cycle.
- Pop latency: `out` updates on the accepting edge N and holds until the next accepted pop.
- Throughput: one row pop per cycle sustained. Each lane accepts one write per cycle.
- Full boundary: the write that makes `cnt_i = depth` raises `o_full` the next cycle. An accepted pop lowers it the cycle after.
- Empty boundary: popping the last row drops `o_valid` the next cycle. A `rd` held high afterwards is ignored.
- Pointer wrap: after `depth` writes, `wp_i` returns to 0. Data order is preserved across the wrap.

## Test plan
- Reset values: assert `reset` mid-cycle with `clk` idle → outputs go immediately to `out`=0, `o_valid`=0, `o_full`=0, `o_ready`=1.
- Skewed fill: lane i writes value 0x100+i starting at cycle i (i = 0..7).
  - `o_valid` rises only in the cycle after lane 7's write.
  - `rd` then gives `out` lane i = 0x100+i.
- Full/drop: write 64 words (values 0..63) to lane 3 only.
  - `o_full`=1 and `o_ready`=0.
  - A 65th write (0xBEEF) is dropped.
  - After filling the other lanes, 64 pops return 0..63 on lane 3 and never 0xBEEF.
- Ignored read: `rd`=1 while lane 5 is empty → `out` and all counts unchanged, `o_valid` stays 0.
- Wrap + concurrency: stream 200 rows with all `wr`=1 and `rd`=1 every cycle after a 4-row prefill.
  - Counts stay at 4.
  - Popped rows are in order, with no loss or duplication across pointer wrap.
- Reset mid-stream: 10 rows buffered, pulse `reset` → `o_valid`=0. A subsequent single row written, then popped, is returned exactly.
